// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Bubbles clear ex_valid/ex_ctl/ex_rt, so a load-use stall can never hold itself for a second cycle.
module id_ex_pipe_reg #(
    parameter int DW     = 32,
    parameter int RW     = 5,
    parameter int ALUOPW = 4,
    parameter int CNTW   = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc4,
    input  logic [DW-1:0]     id_rd1,
    input  logic [DW-1:0]     id_rd2,
    input  logic [DW-1:0]     id_imm,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic [RW-1:0]     id_rd,
    input  logic              id_uses_rt,
    input  logic [9:0]        id_ctl,
    input  logic [ALUOPW-1:0] id_aluop,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc4,
    output logic [DW-1:0]     ex_rd1,
    output logic [DW-1:0]     ex_rd2,
    output logic [DW-1:0]     ex_imm,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rd,
    output logic              ex_uses_rt,
    output logic [9:0]        ex_ctl,
    output logic [ALUOPW-1:0] ex_aluop,
    output logic              hazard_stall,
    output logic [CNTW-1:0]   bubble_cnt
);

    // id_ctl = {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,jump,link,shamt_sel}
    localparam int CTL_MEM_READ = 8;

    logic load_bubble;
    logic cnt_sat;

    always_comb begin
        hazard_stall = ex_valid & ex_ctl[CTL_MEM_READ] & id_valid & (ex_rt != '0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    assign load_bubble = flush | hazard_stall;
    assign cnt_sat     = (bubble_cnt == {CNTW{1'b1}});

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc4     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_uses_rt <= 1'b0;
            ex_ctl     <= '0;
            ex_aluop   <= '0;
        end else if (!ex_stall) begin
            if (load_bubble) begin
                ex_valid   <= 1'b0;
                ex_pc4     <= '0;
                ex_rd1     <= '0;
                ex_rd2     <= '0;
                ex_imm     <= '0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_rd      <= '0;
                ex_uses_rt <= 1'b0;
                ex_ctl     <= '0;
                ex_aluop   <= '0;
            end else begin
                ex_valid   <= id_valid;
                ex_pc4     <= id_pc4;
                ex_rd1     <= id_rd1;
                ex_rd2     <= id_rd2;
                ex_imm     <= id_imm;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_rd      <= id_rd;
                ex_uses_rt <= id_uses_rt;
                ex_ctl     <= id_valid ? id_ctl : 10'd0;
                ex_aluop   <= id_aluop;
            end
        end
    end

    // A flush in the same cycle as a hazard supersedes it, so it is not counted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubble_cnt <= '0;
        end else if (!ex_stall && !flush && hazard_stall && !cnt_sat) begin
            bubble_cnt <= bubble_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: pass-through, load-use, flush/stall priority, reset, saturation.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_id_ex_pipe_reg;

    localparam logic [9:0] CTL_LW  = 10'h360; // reg_write|mem_read|mem_to_reg|alu_src
    localparam logic [9:0] CTL_ADD = 10'h210; // reg_write|reg_dst
    localparam logic [9:0] CTL_ALI = 10'h220; // reg_write|alu_src

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        id_valid;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [9:0]  id_ctl;
    logic [3:0]  id_aluop;
    logic        flush, ex_stall;

    logic        ex_valid, ex_uses_rt, hazard_stall;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [9:0]  ex_ctl;
    logic [3:0]  ex_aluop;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_uses_rt, s_hazard;
    logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [9:0]  s_ctl;
    logic [3:0]  s_aluop;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    id_ex_pipe_reg dut (
        .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_ctl(id_ctl), .id_aluop(id_aluop), .flush(flush),
        .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_uses_rt(ex_uses_rt), .ex_ctl(ex_ctl), .ex_aluop(ex_aluop),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNTW(2)) dut_sat (
        .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_ctl(id_ctl), .id_aluop(id_aluop), .flush(flush),
        .ex_stall(ex_stall), .ex_valid(s_valid), .ex_pc4(s_pc4), .ex_rd1(s_rd1),
        .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_uses_rt(s_uses_rt), .ex_ctl(s_ctl), .ex_aluop(s_aluop),
        .hazard_stall(s_hazard), .bubble_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ur, input logic [9:0] ctl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur; id_ctl = ctl;
        #1;
    endtask

    // lw $8 reaches EX, then add $10,$8,$11 stalls once and follows it.
    task automatic load_use(input int idx);
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd8, 5'd11, 5'd10, 1'b1, CTL_ADD);
        chk($sformatf("sat_hz%0d", idx), hazard_stall, 1'b1);
        step();
        step();
        chk($sformatf("sat_cnt16_%0d", idx), bubble_cnt, 16'(idx));
        chk($sformatf("sat_cnt2_%0d", idx), s_cnt, (idx > 3) ? 2'd3 : 2'(idx));
    endtask

    initial begin
        Rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_aluop = '0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'd0);
        #12;
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_ctl", ex_ctl, 10'd0);
        chk("rst_cnt", bubble_cnt, 16'd0);
        Rst_n = 1'b1;

        // pass-through
        id_pc4 = 32'h0000_0104; id_rd1 = 32'h1234_5678; id_rd2 = 32'hA5A5_5A5A;
        id_imm = 32'hFFFF_8000; id_aluop = 4'h2;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, CTL_ALI);
        chk("pt_no_comb", ex_valid, 1'b0);
        step();
        chk("pt_valid", ex_valid, 1'b1);
        chk("pt_imm", ex_imm, 32'hFFFF_8000);
        chk("pt_rd1", ex_rd1, 32'h1234_5678);
        chk("pt_rd2", ex_rd2, 32'hA5A5_5A5A);
        chk("pt_pc4", ex_pc4, 32'h0000_0104);
        chk("pt_ctl", ex_ctl, CTL_ALI);
        chk("pt_aluop", ex_aluop, 4'h2);
        chk("pt_regs", {ex_rs, ex_rt, ex_rd}, {5'd1, 5'd2, 5'd3});

        // load-use
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        chk("lu_lw_ctl", ex_ctl, CTL_LW);
        drive(1'b1, 5'd8, 5'd11, 5'd10, 1'b1, CTL_ADD);
        chk("lu_hz_on", hazard_stall, 1'b1);
        step();
        chk("lu_bub_valid", ex_valid, 1'b0);
        chk("lu_bub_ctl", ex_ctl, 10'd0);
        chk("lu_cnt", bubble_cnt, 16'd1);
        chk("lu_hz_off", hazard_stall, 1'b0);
        step();
        chk("lu_add_valid", ex_valid, 1'b1);
        chk("lu_add_rs", ex_rs, 5'd8);
        chk("lu_add_ctl", ex_ctl, CTL_ADD);

        // use of rt only counts when id_uses_rt=1
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd4, 5'd8, 5'd10, 1'b1, CTL_ADD);
        chk("lu_rt_hz", hazard_stall, 1'b1);
        drive(1'b1, 5'd4, 5'd8, 5'd0, 1'b0, CTL_ALI);
        chk("lu_rt_nouse", hazard_stall, 1'b0);
        drive(1'b0, 5'd8, 5'd8, 5'd10, 1'b1, CTL_ADD);
        chk("lu_id_invalid", hazard_stall, 1'b0);
        step();
        chk("nop_valid", ex_valid, 1'b0);
        chk("nop_ctl", ex_ctl, 10'd0);

        // lw $0 then use of $0
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, CTL_ADD);
        chk("lw0_no_hz", hazard_stall, 1'b0);
        step();
        // lw $8 then addi with rs=$9, rt=$8 as destination
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_ALI);
        chk("addi_no_hz", hazard_stall, 1'b0);
        step();
        chk("addi_cnt", bubble_cnt, 16'd1);

        // flush beats hazard
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd8, 5'd11, 5'd10, 1'b1, CTL_ADD);
        flush = 1'b1;
        chk("fl_hz", hazard_stall, 1'b1);
        step();
        flush = 1'b0;
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_ctl", ex_ctl, 10'd0);
        chk("fl_cnt", bubble_cnt, 16'd1);

        // ex_stall holds everything while a hazard is pending
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, CTL_LW);
        step();
        drive(1'b1, 5'd8, 5'd11, 5'd10, 1'b1, CTL_ADD);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("st_ctl%0d", i), ex_ctl, CTL_LW);
            chk($sformatf("st_rt%0d", i), ex_rt, 5'd8);
            chk($sformatf("st_cnt%0d", i), bubble_cnt, 16'd1);
            chk($sformatf("st_hz%0d", i), hazard_stall, 1'b1);
        end
        ex_stall = 1'b0;
        step();
        chk("st_rel_valid", ex_valid, 1'b0);
        chk("st_rel_cnt", bubble_cnt, 16'd2);
        step();
        chk("st_add_ctl", ex_ctl, CTL_ADD);

        // asynchronous reset mid-cycle
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", ex_valid, 1'b0);
        chk("ar_ctl", ex_ctl, 10'd0);
        chk("ar_rd1", ex_rd1, 32'd0);
        chk("ar_imm", ex_imm, 32'd0);
        chk("ar_cnt", bubble_cnt, 16'd0);
        chk("ar_cnt2", s_cnt, 2'd0);
        step();
        #3;
        Rst_n = 1'b1;

        // saturation of the 2-bit counter
        for (int i = 1; i <= 5; i++) load_use(i);
        step();
        chk("sat_hold", s_cnt, 2'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
